// File: rtl/thermo_ctrl_if.sv
// Sensor-side and drive-side signals of the thermostat controller.
// The master drives mode and temperatures; the slave (controller) returns the HVAC enables and status.
interface thermo_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
);
  logic [1:0]       mode;
  logic [WIDTH-1:0] Tset;
  logic [WIDTH-1:0] Tact;
  logic             Hon;
  logic             Con;
  logic [1:0]       state;
  logic [CNTW-1:0]  starts;

  modport master (
    output mode, Tset, Tact,
    input  Hon, Con, state, starts
  );

  modport slave (
    input  mode, Tset, Tact,
    output Hon, Con, state, starts
  );
endinterface

// File: rtl/thermo_ctrl.sv
// Thermostat controller: hysteretic heat/cool decision with minimum on-time,
// fixed rest period between activations, mode gating and a saturating start counter.
module thermo_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BAND    = 4,
  parameter int unsigned MIN_ON  = 16,
  parameter int unsigned MIN_OFF = 16,
  parameter int unsigned CNTW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  thermo_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HEAT = 2'b01;
  localparam logic [1:0] S_COOL = 2'b10;
  localparam logic [1:0] S_REST = 2'b11;

  localparam int unsigned CMAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam logic signed [WIDTH:0] BAND_S = (WIDTH+1)'(BAND);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CNTW-1:0]     starts_q, starts_d;
  logic                hon_q, con_q;
  logic                start_c;

  logic signed [WIDTH:0] diff_c;
  logic                  heat_req_c, cool_req_c;
  logic                  diff_le0_c, diff_ge0_c;
  logic                  on_done_c, rest_done_c;

  // Zero-extended signed difference: no modular wrap between far-apart operands.
  assign diff_c      = $signed({1'b0, bus.Tset}) - $signed({1'b0, bus.Tact});
  assign heat_req_c  = bus.mode[0] && (diff_c >= BAND_S);
  assign cool_req_c  = bus.mode[1] && (diff_c <= -BAND_S);
  assign diff_le0_c  = diff_c[WIDTH] || (diff_c == '0);
  assign diff_ge0_c  = !diff_c[WIDTH];
  assign on_done_c   = (cnt_q >= CW'(MIN_ON - 1));
  assign rest_done_c = (cnt_q == CW'(MIN_OFF - 1));

  // Next-state decision; every exit from an active state goes through REST.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (heat_req_c) begin
          state_d = S_HEAT;
          start_c = 1'b1;
        end else if (cool_req_c) begin
          state_d = S_COOL;
          start_c = 1'b1;
        end
      end
      S_HEAT: begin
        if (!bus.mode[0] || (diff_le0_c && on_done_c)) state_d = S_REST;
      end
      S_COOL: begin
        if (!bus.mode[1] || (diff_ge0_c && on_done_c)) state_d = S_REST;
      end
      S_REST: begin
        if (rest_done_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dwell counter restarts on every state change; start counter saturates.
  always_comb begin
    cnt_d    = cnt_q;
    starts_d = starts_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(CMAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (start_c && (starts_q != '1)) begin
      starts_d = starts_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      starts_q <= '0;
      hon_q    <= 1'b0;
      con_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starts_q <= starts_d;
      hon_q    <= (state_d == S_HEAT);
      con_q    <= (state_d == S_COOL);
    end
  end

  assign bus.Hon    = hon_q;
  assign bus.Con    = con_q;
  assign bus.state  = state_q;
  assign bus.starts = starts_q;

endmodule

// File: tb/tb_thermo_ctrl.sv
// Self-checking bench for thermo_ctrl: directed vector table, hand-written corner sequences,
// and randomized stimulus against a time-in-state reference model.
module tb_thermo_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thermo_ctrl_if #(.WIDTH(8), .CNTW(16)) bus ();
  thermo_ctrl_if #(.WIDTH(8), .CNTW(2))  bus_s ();

  assign bus_s.mode = bus.mode;
  assign bus_s.Tset = bus.Tset;
  assign bus_s.Tact = bus.Tact;

  thermo_ctrl #(.WIDTH(8), .BAND(4), .MIN_ON(4), .MIN_OFF(3), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Second instance with a 2-bit start counter so saturation is reachable quickly.
  thermo_ctrl #(.WIDTH(8), .BAND(4), .MIN_ON(1), .MIN_OFF(1), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: state code, cycles spent in current state (1 on entry), total starts.
  int m_st[2];
  int m_age[2];
  int m_starts[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input bit r, input bit [1:0] md, input int ts, input int ta);
    int d, mon, moff, nxt;
    mon  = (id == 0) ? 4 : 1;
    moff = (id == 0) ? 3 : 1;
    d    = ts - ta;
    if (r) begin
      m_st[id] = 0; m_age[id] = 1; m_starts[id] = 0;
      return;
    end
    nxt = m_st[id];
    case (m_st[id])
      0: begin
        if (md[0] && d >= 4)       begin nxt = 1; m_starts[id]++; end
        else if (md[1] && -d >= 4) begin nxt = 2; m_starts[id]++; end
      end
      1: if (!md[0] || (d <= 0 && m_age[id] >= mon)) nxt = 3;
      2: if (!md[1] || (d >= 0 && m_age[id] >= mon)) nxt = 3;
      default: if (m_age[id] == moff) nxt = 0;
    endcase
    if (nxt != m_st[id]) m_age[id] = 1;
    else                 m_age[id]++;
    m_st[id] = nxt;
  endtask

  // One clock: advance both models with the inputs seen at the edge, then check the saturating instance.
  task automatic step();
    @(posedge clk);
    model_step(0, rst, bus.mode, int'(bus.Tset), int'(bus.Tact));
    model_step(1, rst, bus.mode, int'(bus.Tset), int'(bus.Tact));
    #1;
    chk("sat_state",  int'(bus_s.state), m_st[1]);
    chk("sat_hon",    int'(bus_s.Hon),   (m_st[1] == 1) ? 1 : 0);
    chk("sat_con",    int'(bus_s.Con),   (m_st[1] == 2) ? 1 : 0);
    chk("sat_starts", int'(bus_s.starts), (m_starts[1] > 3) ? 3 : m_starts[1]);
  endtask

  task automatic chk_main(input string tag, input int hon, input int con, input int st, input int starts);
    chk({tag, "_hon"},    int'(bus.Hon),    hon);
    chk({tag, "_con"},    int'(bus.Con),    con);
    chk({tag, "_state"},  int'(bus.state),  st);
    chk({tag, "_starts"}, int'(bus.starts), starts);
  endtask

  task automatic chk_model(input string tag);
    chk_main(tag, (m_st[0] == 1) ? 1 : 0, (m_st[0] == 2) ? 1 : 0, m_st[0],
             (m_starts[0] > 65535) ? 65535 : m_starts[0]);
  endtask

  task automatic drive(input bit [1:0] md, input int ts, input int ta);
    bus.mode = md;
    bus.Tset = 8'(ts);
    bus.Tact = 8'(ta);
  endtask

  typedef struct {
    bit       r;
    bit [1:0] md;
    int       ts;
    int       ta;
    int       hon;
    int       con;
    int       st;
    int       starts;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int hold, c, ts, ta;
    bit [1:0] md;

    // Heat cycle, deadband, hysteresis, no-wrap cooling and mode-01 lockout.
    tbl.push_back('{0, 2'b11, 70,  66, 1, 0, 1, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 1, 0, 1, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 1, 0, 1, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 1, 0, 1, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 1});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 0, 1});
    tbl.push_back('{0, 2'b11, 70,  67, 0, 0, 0, 1});
    tbl.push_back('{0, 2'b11, 70,  73, 0, 0, 0, 1});
    tbl.push_back('{0, 2'b11, 70,  66, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  68, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  68, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  68, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  68, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  69, 1, 0, 1, 2});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 2});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 2});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 3, 2});
    tbl.push_back('{0, 2'b11, 70,  70, 0, 0, 0, 2});
    tbl.push_back('{0, 2'b11,  2, 250, 0, 1, 2, 3});
    tbl.push_back('{0, 2'b11,  2, 250, 0, 1, 2, 3});
    tbl.push_back('{0, 2'b11,  2, 250, 0, 1, 2, 3});
    tbl.push_back('{0, 2'b01,  2, 250, 0, 0, 3, 3});
    tbl.push_back('{0, 2'b01,  2, 250, 0, 0, 3, 3});
    tbl.push_back('{0, 2'b01,  2, 250, 0, 0, 3, 3});
    tbl.push_back('{0, 2'b01,  2, 250, 0, 0, 0, 3});
    tbl.push_back('{0, 2'b01,  2, 250, 0, 0, 0, 3});

    // Reset with arbitrary inputs.
    rst = 1'b1;
    drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    step();
    step();
    chk_main("reset", 0, 0, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      rst = tbl[i].r;
      drive(tbl[i].md, tbl[i].ts, tbl[i].ta);
      step();
      chk_main($sformatf("vec%0d", i), tbl[i].hon, tbl[i].con, tbl[i].st, tbl[i].starts);
    end

    // Mode override at cnt=1 in HEAT ignores MIN_ON; idle stays idle with mode off.
    drive(2'b11, 70, 60);
    step(); chk_main("ovr_enter", 1, 0, 1, 4);
    step(); chk_main("ovr_cnt1",  1, 0, 1, 4);
    bus.mode = 2'b00;
    step(); chk_main("ovr_drop",  0, 0, 3, 4);
    step(); chk_main("ovr_rest2", 0, 0, 3, 4);
    step(); chk_main("ovr_rest3", 0, 0, 3, 4);
    step(); chk_main("ovr_idle",  0, 0, 0, 4);
    repeat (3) begin
      step(); chk_main("ovr_hold", 0, 0, 0, 4);
    end

    // Reset mid-COOL goes straight to IDLE, then cooling resumes with no REST.
    drive(2'b11, 2, 250);
    step(); chk_main("rc_cool", 0, 1, 2, 5);
    step(); chk_main("rc_cool2", 0, 1, 2, 5);
    rst = 1'b1;
    step(); chk_main("rc_reset", 0, 0, 0, 0);
    rst = 1'b0;
    step(); chk_main("rc_again", 0, 1, 2, 1);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_model("rnd_init");
    c = 0;
    while (c < 600) begin
      hold = int'($urandom_range(1, 6));
      md   = 2'($urandom_range(0, 3));
      ts   = int'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        ta = ts + int'($urandom_range(0, 12)) - 6;
        if (ta < 0)   ta = 0;
        if (ta > 255) ta = 255;
      end else begin
        ta = int'($urandom_range(0, 255));
      end
      drive(md, ts, ta);
      rst = ($urandom_range(0, 63) == 0);
      repeat (hold) begin
        step();
        chk_model("rnd");
        rst = 1'b0;
        c++;
      end
    end

    chk("sat_final", int'(bus_s.starts), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thermo_ctrl.md
# thermo_ctrl

Sequential thermostat controller and parametrised successor to the team's combinational thermostat comparator. It compares a setpoint against a measured temperature of configurable width, and drives one heater enable and one cooler enable. Its behaviour adds:
- a deadband with hysteresis, so an output switches off at the setpoint rather than at the turn-on threshold;
- minimum on-time and minimum rest-time protection for the plant;
- a mode select: off, heat-only, cool-only or auto;
- a saturating activation counter.

It sits between the temperature sensor interface and the HVAC drive outputs.

## Interface
Parameters:
- WIDTH, 8, bit width of the temperature operands (unsigned).
- BAND, 4, turn-on threshold in LSBs; legal range 1 .. 2^WIDTH-1.
- MIN_ON, 16, minimum cycles an output stays high once asserted; must be ≥ 1.
- MIN_OFF, 16, cycles spent in REST after any output turns off; must be ≥ 1.
- CNTW, 16, width of the activation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  operating mode: 00 off, 01 heat-only, 10 cool-only, 11 auto.
- Tset  in  WIDTH  setpoint, unsigned.
- Tact  in  WIDTH  measured temperature, unsigned.
- Hon  out  1  heater enable; high iff state is HEAT.
- Con  out  1  cooler enable; high iff state is COOL.
- state  out  2  current state: 00 IDLE, 01 HEAT, 10 COOL, 11 REST.
- starts  out  CNTW  count of IDLE→HEAT plus IDLE→COOL transitions; saturates at all-ones.

## Operation
Arithmetic:
- diff = Tset − Tact, computed in WIDTH+1 bits signed, with both operands zero-extended. There is no modular wrap.
- heat_req = diff ≥ BAND, and mode[0] = 1.
- cool_req = −diff ≥ BAND, and mode[1] = 1.
- Because BAND ≥ 1, heat_req and cool_req can never both be true.

Registers:
- A 2-bit state register.
- A dwell counter `cnt`. It clears to 0 on every state change, otherwise increments, and saturates at max(MIN_ON, MIN_OFF).

State machine:
- IDLE
  - heat_req → HEAT, and starts increments.
  - else cool_req → COOL, and starts increments.
  - else stay in IDLE.
- HEAT
  - If mode[0] = 0, go to REST immediately. This safety override ignores MIN_ON.
  - Else if diff ≤ 0 and cnt ≥ MIN_ON−1, go to REST.
  - Else stay in HEAT.
- COOL
  - If mode[1] = 0, go to REST immediately.
  - Else if diff ≥ 0 and cnt ≥ MIN_ON−1, go to REST.
  - Else stay in COOL.
- REST
  - Hon = Con = 0, and demand is ignored.
  - Go to IDLE when cnt = MIN_OFF−1.
- HEAT never goes directly to COOL, and COOL never goes directly to HEAT. Every exit from HEAT or COOL passes through REST.

## Timing
Reset:
- rst is sampled on the rising edge of clk and has priority over all other logic.
- After the reset edge: state = IDLE, cnt = 0, starts = 0, Hon = 0, Con = 0.
- Reset taken during HEAT, COOL or REST goes straight to IDLE. It does not enforce a REST period.

Sampling and latency:
- Tset, Tact and mode are sampled at each rising edge.
- Hon, Con and state are decoded directly from the state register, with no combinational path from the inputs.
- Latency is 1 cycle: a request present before edge k gives an asserted output immediately after edge k.

Dwell times:
- An output that exits on its normal condition stays high for at least MIN_ON cycles. If the setpoint is not yet met, it stays high longer.
- REST always lasts exactly MIN_OFF cycles.
- The earliest re-assertion after an output drops is therefore MIN_OFF+1 edges later: MIN_OFF cycles in REST, then one cycle in IDLE for the decision.

Boundary conditions:
- diff = BAND − 1 is inside the deadband: no transition.
- diff = 0 satisfies the exit condition for both HEAT and COOL.
- When starts is all-ones, it holds its value.
- A mode change takes effect on the next edge.

## Test plan
All scenarios use WIDTH=8, BAND=4, MIN_ON=4, MIN_OFF=3, CNTW=16.
- Reset: assert rst for 2 cycles with arbitrary inputs → Hon=0, Con=0, state=00, starts=0.
- Heat cycle: mode=11, Tset=70, Tact=66. Then set Tact=70 one cycle after Hon rises.
  - Hon is high for exactly 4 cycles.
  - state then shows 11 for 3 cycles, then 00.
  - starts=1.
- Deadband and hysteresis:
  - Tset=70 with Tact=67 or Tact=73 → no output.
  - In HEAT with Tact=68 after MIN_ON has elapsed → Hon stays high until Tact ≥ 70.
- No wrap: Tset=2, Tact=250, mode=11 → Con asserts and Hon never asserts. With mode=01 and the same temperatures → nothing asserts.
- Mode override: in HEAT at cnt=1, drive mode=00 → Hon drops after the next edge, then REST lasts 3 cycles. After that, IDLE stays idle even though the temperatures are unchanged.
- Reset mid-COOL: assert rst while Con=1 → after the edge Con=0 and state=00. With cool demand still present, Con re-asserts after the following edge, with no REST in between.
